sine_phase_gen: RTL and testbench



---
 rtl/sine_phase_gen.sv | 178 +++++++++++++++++
 tb/tb_sine_phase_gen.sv | 212 +++++++++++++++++++++
 2 files changed

// File: rtl/sine_phase_gen.sv
`default_nettype none
// ============================================================================
// Module   : sine_phase_gen
// Purpose  : DDS sine source. A programmable phase accumulator advances on
//            each accepted tick. A quarter-wave table maps the phase to an
//            offset-binary sine sample. The sample leaves two clocks after
//            its tick, together with a one-cycle valid strobe.
// Revision : 1.0  initial release
// ============================================================================
module sine_phase_gen #(
  parameter int PHASE_W    = 16,
  parameter int LUT_ADDR_W = 6,
  parameter int OUT_W      = 8
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               ena,
  input  logic [PHASE_W-1:0] freq_word,
  input  logic               freq_load,
  input  logic               phase_clr,
  input  logic               tick,
  output logic [OUT_W-1:0]   sample_out,
  output logic               sample_valid,
  output logic [1:0]         quadrant
);

  localparam int MAG_W = OUT_W - 1;
  localparam logic [LUT_ADDR_W-1:0] C_IDX_MAX = {LUT_ADDR_W{1'b1}};
  localparam logic [OUT_W-1:0]      C_MID     = 8'h80;
  localparam logic [OUT_W-1:0]      C_MID_M1  = 8'h7F;

  // Accumulator and frequency register
  logic [PHASE_W-1:0] freq_q, freq_d;
  logic [PHASE_W-1:0] phase_q, phase_d;

  // Stage 1: decoded quadrant and table index of the sampled phase
  logic                  s1_valid_q, s1_valid_d;
  logic [1:0]            s1_quad_q, s1_quad_d;
  logic [LUT_ADDR_W-1:0] s1_idx_q, s1_idx_d;

  // Stage 2: registered table magnitude
  logic                  s2_valid_q, s2_valid_d;
  logic [1:0]            s2_quad_q, s2_quad_d;
  logic [MAG_W-1:0]      s2_mag_q, s2_mag_d;

  // Output registers
  logic                  out_valid_q, out_valid_d;
  logic [1:0]            out_quad_q, out_quad_d;
  logic [OUT_W-1:0]      out_sample_q, out_sample_d;

  logic                  accept;
  logic [1:0]            phase_quad;
  logic [LUT_ADDR_W-1:0] phase_frac;
  logic [MAG_W-1:0]      lut_mag;

  assign accept     = tick & ena;
  assign phase_quad = phase_q[PHASE_W-1 -: 2];
  assign phase_frac = phase_q[PHASE_W-3 -: LUT_ADDR_W];

  // Quarter-wave table: round(127*sin(pi/2*(i+0.5)/64))
  always_comb begin
    lut_mag = '0;
    case (s1_idx_q)
      6'd0:  lut_mag = 7'd2;    6'd1:  lut_mag = 7'd5;
      6'd2:  lut_mag = 7'd8;    6'd3:  lut_mag = 7'd11;
      6'd4:  lut_mag = 7'd14;   6'd5:  lut_mag = 7'd17;
      6'd6:  lut_mag = 7'd20;   6'd7:  lut_mag = 7'd23;
      6'd8:  lut_mag = 7'd26;   6'd9:  lut_mag = 7'd29;
      6'd10: lut_mag = 7'd32;   6'd11: lut_mag = 7'd35;
      6'd12: lut_mag = 7'd38;   6'd13: lut_mag = 7'd41;
      6'd14: lut_mag = 7'd44;   6'd15: lut_mag = 7'd47;
      6'd16: lut_mag = 7'd50;   6'd17: lut_mag = 7'd53;
      6'd18: lut_mag = 7'd56;   6'd19: lut_mag = 7'd58;
      6'd20: lut_mag = 7'd61;   6'd21: lut_mag = 7'd64;
      6'd22: lut_mag = 7'd67;   6'd23: lut_mag = 7'd69;
      6'd24: lut_mag = 7'd72;   6'd25: lut_mag = 7'd74;
      6'd26: lut_mag = 7'd77;   6'd27: lut_mag = 7'd79;
      6'd28: lut_mag = 7'd82;   6'd29: lut_mag = 7'd84;
      6'd30: lut_mag = 7'd86;   6'd31: lut_mag = 7'd89;
      6'd32: lut_mag = 7'd91;   6'd33: lut_mag = 7'd93;
      6'd34: lut_mag = 7'd95;   6'd35: lut_mag = 7'd97;
      6'd36: lut_mag = 7'd99;   6'd37: lut_mag = 7'd101;
      6'd38: lut_mag = 7'd103;  6'd39: lut_mag = 7'd105;
      6'd40: lut_mag = 7'd106;  6'd41: lut_mag = 7'd108;
      6'd42: lut_mag = 7'd110;  6'd43: lut_mag = 7'd111;
      6'd44: lut_mag = 7'd113;  6'd45: lut_mag = 7'd114;
      6'd46: lut_mag = 7'd115;  6'd47: lut_mag = 7'd117;
      6'd48: lut_mag = 7'd118;  6'd49: lut_mag = 7'd119;
      6'd50: lut_mag = 7'd120;  6'd51: lut_mag = 7'd121;
      6'd52: lut_mag = 7'd122;  6'd53: lut_mag = 7'd123;
      6'd54: lut_mag = 7'd124;  6'd55: lut_mag = 7'd124;
      6'd56: lut_mag = 7'd125;  6'd57: lut_mag = 7'd125;
      6'd58: lut_mag = 7'd126;  6'd59: lut_mag = 7'd126;
      6'd60: lut_mag = 7'd127;  6'd61: lut_mag = 7'd127;
      6'd62: lut_mag = 7'd127;  6'd63: lut_mag = 7'd127;
      default: lut_mag = '0;
    endcase
  end

  // Next-state: accumulator, frequency register and pipeline advance
  always_comb begin
    freq_d       = freq_q;
    phase_d      = phase_q;
    s1_valid_d   = accept;
    s1_quad_d    = s1_quad_q;
    s1_idx_d     = s1_idx_q;
    s2_valid_d   = s1_valid_q;
    s2_quad_d    = s2_quad_q;
    s2_mag_d     = s2_mag_q;
    out_valid_d  = s2_valid_q;
    out_quad_d   = out_quad_q;
    out_sample_d = out_sample_q;

    if (freq_load) begin
      freq_d = freq_word;
    end

    // The increment uses the freq_q in place before any same-cycle load;
    // a clear overrides the increment but the tick still samples the old phase.
    if (phase_clr) begin
      phase_d = '0;
    end else if (accept) begin
      phase_d = phase_q + freq_q;
    end

    if (accept) begin
      s1_quad_d = phase_quad;
      s1_idx_d  = phase_quad[0] ? (C_IDX_MAX - phase_frac) : phase_frac;
    end

    if (s1_valid_q) begin
      s2_quad_d = s1_quad_q;
      s2_mag_d  = lut_mag;
    end

    // Upper half-cycle sits above mid-scale, lower half mirrors below it.
    if (s2_valid_q) begin
      out_quad_d   = s2_quad_q;
      out_sample_d = s2_quad_q[1] ? (C_MID_M1 - {1'b0, s2_mag_q})
                                  : (C_MID + {1'b0, s2_mag_q});
    end
  end

  // State registers with synchronous active-low reset
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      freq_q       <= '0;
      phase_q      <= '0;
      s1_valid_q   <= 1'b0;
      s1_quad_q    <= '0;
      s1_idx_q     <= '0;
      s2_valid_q   <= 1'b0;
      s2_quad_q    <= '0;
      s2_mag_q     <= '0;
      out_valid_q  <= 1'b0;
      out_quad_q   <= '0;
      out_sample_q <= C_MID;
    end else begin
      freq_q       <= freq_d;
      phase_q      <= phase_d;
      s1_valid_q   <= s1_valid_d;
      s1_quad_q    <= s1_quad_d;
      s1_idx_q     <= s1_idx_d;
      s2_valid_q   <= s2_valid_d;
      s2_quad_q    <= s2_quad_d;
      s2_mag_q     <= s2_mag_d;
      out_valid_q  <= out_valid_d;
      out_quad_q   <= out_quad_d;
      out_sample_q <= out_sample_d;
    end
  end

  assign sample_out   = out_sample_q;
  assign sample_valid = out_valid_q;
  assign quadrant     = out_quad_q;

endmodule
`default_nettype wire

// File: tb/tb_sine_phase_gen.sv
`default_nettype none
// ============================================================================
// Module   : tb_sine_phase_gen
// Purpose  : Self-checking bench for sine_phase_gen. A transaction-level model
//            computes each sample from the phase with real-valued sine
//            arithmetic and schedules it two edges after its tick.
// Revision : 1.0  initial release
// ============================================================================
module tb_sine_phase_gen;

  localparam int PW = 16;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          ena = 1'b0;
  logic [PW-1:0] freq_word = '0;
  logic          freq_load = 1'b0;
  logic          phase_clr = 1'b0;
  logic          tick = 1'b0;
  logic [7:0]    sample_out;
  logic          sample_valid;
  logic [1:0]    quadrant;

  sine_phase_gen #(.PHASE_W(PW), .LUT_ADDR_W(6), .OUT_W(8)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .ena          (ena),
    .freq_word    (freq_word),
    .freq_load    (freq_load),
    .phase_clr    (phase_clr),
    .tick         (tick),
    .sample_out   (sample_out),
    .sample_valid (sample_valid),
    .quadrant     (quadrant)
  );

  always #5 clk = ~clk;

  typedef struct {
    int due;
    int smp;
    int quad;
  } exp_t;

  int   n_vec  = 0;
  int   n_miss = 0;
  int   cyc    = 0;
  exp_t pend[$];
  int   got_q[$];

  // Model state
  int m_phase = 0;
  int m_freq  = 0;
  int m_out   = 8'h80;
  int m_quad  = 0;
  int m_valid = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_miss++;
      $display("FAIL %s at cycle %0d: got %0d expected %0d", tag, cyc, got, exp);
    end
  endtask

  // Sine of the truncated phase, offset binary, from real arithmetic.
  function automatic int ref_sample(input int ph, output int q);
    int  a, idx, m;
    real x;
    q   = (ph >> (PW - 2)) & 3;
    a   = (ph >> (PW - 8)) & 63;
    idx = (q == 1 || q == 3) ? 63 - a : a;
    x   = 127.0 * $sin(3.14159265358979 / 2.0 * (real'(idx) + 0.5) / 64.0);
    m   = $rtoi($floor(x + 0.5));
    return (q < 2) ? 128 + m : 127 - m;
  endfunction

  task automatic model_edge();
    exp_t e;
    int   q;
    cyc++;
    if (!rst_n) begin
      pend.delete();
      m_phase = 0;
      m_freq  = 0;
      m_out   = 8'h80;
      m_quad  = 0;
      m_valid = 0;
      return;
    end
    if (tick && ena) begin
      e.due  = cyc + 2;
      e.smp  = ref_sample(m_phase, q);
      e.quad = q;
      pend.push_back(e);
      m_phase = (m_phase + m_freq) % (1 << PW);
    end
    if (phase_clr) m_phase = 0;
    if (freq_load) m_freq = int'(freq_word);
    m_valid = 0;
    if (pend.size() > 0 && pend[0].due == cyc) begin
      e = pend.pop_front();
      m_valid = 1;
      m_out   = e.smp;
      m_quad  = e.quad;
    end
  endtask

  task automatic step();
    @(posedge clk);
    model_edge();
    #1;
    if (sample_valid === 1'b1) got_q.push_back(int'(sample_out));
    check("sample_valid", {31'd0, sample_valid}, m_valid);
    check("sample_out", {24'd0, sample_out}, m_out);
    check("quadrant", {30'd0, quadrant}, m_quad);
  endtask

  task automatic idle(input int n);
    tick = 1'b0; freq_load = 1'b0; phase_clr = 1'b0;
    for (int i = 0; i < n; i++) step();
  endtask

  task automatic expect_seq(input string tag, input int e[$]);
    check({tag, "_count"}, got_q.size(), e.size());
    for (int i = 0; i < e.size() && i < got_q.size(); i++)
      check(tag, got_q[i], e[i]);
    got_q.delete();
  endtask

  task automatic load_and_clear(input int f);
    freq_word = f[PW-1:0]; freq_load = 1'b1; phase_clr = 1'b1; tick = 1'b0;
    step();
    freq_load = 1'b0; phase_clr = 1'b0;
  endtask

  initial begin
    int e[$];
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int e[$];
    // Reset with tick held high, then release quietly
    rst_n = 1'b0; ena = 1'b1; tick = 1'b1;
    step(); step();
    check("rst_sample", {24'd0, sample_out}, 32'h80);
    check("rst_valid", {31'd0, sample_valid}, 0);
    rst_n = 1'b1; tick = 1'b0;
    idle(3);
    got_q.delete();

    // Latency and first values
    freq_word = 16'h0400; freq_load = 1'b1; step(); freq_load = 1'b0;
    tick = 1'b1; step(); step(); tick = 1'b0; idle(4);
    e = '{130, 142}; expect_seq("lat_vals", e);

    // Quadrants and wrap, back-to-back
    load_and_clear(16'h4000);
    tick = 1'b1; for (int i = 0; i < 5; i++) step();
    idle(4);
    e = '{130, 255, 125, 0, 130}; expect_seq("quad_wrap", e);

    // freq_load together with a tick keeps the old increment for that tick
    load_and_clear(16'h4000);
    tick = 1'b1; step();
    freq_word = 16'h8000; freq_load = 1'b1; step();
    freq_load = 1'b0; step(); step();
    idle(4);
    e = '{130, 255, 125, 130}; expect_seq("fload_tick", e);

    // phase_clr together with a tick at phase 0x8000, then ena low
    load_and_clear(16'h4000);
    tick = 1'b1; step(); step();
    phase_clr = 1'b1; step(); phase_clr = 1'b0;
    step();
    tick = 1'b0; idle(3);
    ena = 1'b0; tick = 1'b1; step(); step(); step();
    tick = 1'b0; idle(3);
    ena = 1'b1; tick = 1'b1; step(); tick = 1'b0; idle(4);
    e = '{130, 255, 125, 130, 255}; expect_seq("clr_ena", e);

    // Reset while a sample is in flight
    tick = 1'b1; step(); tick = 1'b0;
    rst_n = 1'b0; step(); rst_n = 1'b1;
    idle(4);
    e = '{}; expect_seq("rst_flush", e);
    freq_word = 16'h4000; freq_load = 1'b1; step(); freq_load = 1'b0;
    tick = 1'b1; step(); tick = 1'b0; idle(4);
    e = '{130}; expect_seq("post_rst", e);

    // Randomized traffic
    for (int i = 0; i < 1500; i++) begin
      tick      = ($urandom_range(0, 99) < 70);
      ena       = ($urandom_range(0, 99) < 85);
      freq_load = ($urandom_range(0, 99) < 6);
      freq_word = 16'($urandom);
      phase_clr = ($urandom_range(0, 99) < 3);
      rst_n     = ($urandom_range(0, 199) != 0);
      step();
    end
    rst_n = 1'b1; ena = 1'b1;
    idle(4);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
`default_nettype wire
